// File: rtl/hilo_ctrl.sv
// HI/LO owner: sequences the shared multiplier and divider for MULT/MULTU/DIV/DIVU/MTHI/MTLO
// and commits their results to the architectural HI/LO registers.
module hilo_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [1:0]  mul_op,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [63:0] mul_result,
  output logic [1:0]  div_op,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  output logic        div_in_valid,
  input  logic [63:0] div_result,
  input  logic        div_out_valid,
  output logic        div_out_ready,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic        hilo_busy
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_ISSUE,
    DIV_WAIT,
    DIV_DRAIN
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        accept;
  logic        op_onehot;

  // NOTE: ready depends combinationally on flush so a flushed cycle can never accept.
  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  // Malformed encodings (no bit or several bits set) are accepted but do nothing.
  assign op_onehot = (req_op != 6'd0) && ((req_op & (req_op - 6'd1)) == 6'd0);

  assign hilo_busy = (state != IDLE);
  assign hi_rdata  = hi;
  assign lo_rdata  = lo;

  // NOTE: sequential state uses non-blocking assignments only; every register, including
  // operands, is cleared by the synchronous reset so an abandoned operation leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      hi            <= 32'd0;
      lo            <= 32'd0;
      mul_op        <= 2'd0;
      mul_src1      <= 32'd0;
      mul_src2      <= 32'd0;
      div_op        <= 2'd0;
      dividend      <= 32'd0;
      divisor       <= 32'd0;
      div_in_valid  <= 1'b0;
      div_out_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && op_onehot) begin
            if (req_op[5]) hi <= req_src1;
            if (req_op[4]) lo <= req_src1;
            if (|req_op[1:0]) begin
              mul_op   <= req_op[1:0];
              mul_src1 <= req_src1;
              mul_src2 <= req_src2;
              cnt      <= 4'd0;
              state    <= MUL;
            end
            if (|req_op[3:2]) begin
              div_op       <= req_op[3:2];
              dividend     <= req_src1;
              divisor      <= req_src2;
              div_in_valid <= 1'b1;
              state        <= DIV_ISSUE;
            end
          end
        end
        MUL: begin
          if (flush) begin
            mul_op <= 2'd0;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            hi     <= mul_result[63:32];
            lo     <= mul_result[31:0];
            mul_op <= 2'd0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DIV_ISSUE: begin
          div_in_valid  <= 1'b0;
          div_out_ready <= 1'b1;
          state         <= flush ? DIV_DRAIN : DIV_WAIT;
        end
        DIV_WAIT: begin
          if (div_out_valid) begin
            if (!flush) begin
              hi <= div_result[63:32];
              lo <= div_result[31:0];
            end
            div_out_ready <= 1'b0;
            div_op        <= 2'd0;
            state         <= IDLE;
          end else if (flush) begin
            state <= DIV_DRAIN;
          end
        end
        DIV_DRAIN: begin
          // Operands and div_op stay put until the divider hands back its (discarded) result.
          if (div_out_valid) begin
            div_out_ready <= 1'b0;
            div_op        <= 2'd0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: transaction-level HI/LO model, external multiplier and
// divider models, directed scenarios followed by randomized traffic.
module tb_hilo_ctrl;

  localparam int LAT = 4;
  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTLO  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (MUL_LAT = LAT)
  logic        rst, flush, req_valid, req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic [1:0]  mul_op, div_op;
  logic [31:0] mul_src1, mul_src2, dividend, divisor;
  logic [63:0] mul_result, div_result;
  logic        div_in_valid, div_out_valid, div_out_ready;
  logic [31:0] hi_rdata, lo_rdata;
  logic        hilo_busy;

  // Second DUT with MUL_LAT = 1, multiply-only traffic
  logic        l_flush, l_req_valid, l_req_ready;
  logic [5:0]  l_req_op;
  logic [31:0] l_src1, l_src2;
  logic [1:0]  l_mul_op, l_div_op;
  logic [31:0] l_mul_src1, l_mul_src2, l_dividend, l_divisor;
  logic [63:0] l_mul_result, l_div_result;
  logic        l_div_in_valid, l_div_out_valid, l_div_out_ready;
  logic [31:0] l_hi, l_lo;
  logic        l_busy;

  assign l_flush         = 1'b0;
  assign l_div_result    = 64'd0;
  assign l_div_out_valid = 1'b0;

  hilo_ctrl #(.MUL_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .mul_op(mul_op), .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
    .div_op(div_op), .dividend(dividend), .divisor(divisor),
    .div_in_valid(div_in_valid), .div_result(div_result),
    .div_out_valid(div_out_valid), .div_out_ready(div_out_ready),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .hilo_busy(hilo_busy)
  );

  hilo_ctrl #(.MUL_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .flush(l_flush),
    .req_valid(l_req_valid), .req_ready(l_req_ready), .req_op(l_req_op),
    .req_src1(l_src1), .req_src2(l_src2),
    .mul_op(l_mul_op), .mul_src1(l_mul_src1), .mul_src2(l_mul_src2), .mul_result(l_mul_result),
    .div_op(l_div_op), .dividend(l_dividend), .divisor(l_divisor),
    .div_in_valid(l_div_in_valid), .div_result(l_div_result),
    .div_out_valid(l_div_out_valid), .div_out_ready(l_div_out_ready),
    .hi_rdata(l_hi), .lo_rdata(l_lo), .hilo_busy(l_busy)
  );

  function automatic logic [63:0] mul_fn(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Divider answer: {remainder, quotient}; divide by zero returns {dividend, all ones}.
  function automatic logic [63:0] div_fn(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  assign mul_result   = mul_fn(mul_op[0], mul_src1, mul_src2);
  assign l_mul_result = mul_fn(l_mul_op[0], l_mul_src1, l_mul_src2);

  // External divider: starts on div_in_valid, answers div_lat cycles later, holds until taken.
  int unsigned div_lat = 10;
  initial begin
    int unsigned cnt;
    logic r, iv, ordy, ov, sg;
    logic [31:0] a, b;
    cnt = 0;
    div_out_valid = 1'b0;
    div_result = 64'd0;
    forever begin
      @(posedge clk);
      r = rst; iv = div_in_valid; ordy = div_out_ready; ov = div_out_valid;
      sg = div_op[0]; a = dividend; b = divisor;
      #1;
      if (r) begin
        div_out_valid = 1'b0;
        cnt = 0;
      end else begin
        if (ov && ordy) div_out_valid = 1'b0;
        if (iv) begin
          div_result = div_fn(sg, a, b);
          cnt = div_lat;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) div_out_valid = 1'b1;
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what is outstanding and what HI/LO must hold.
  typedef enum {K_NONE, K_MUL, K_DIV} kind_t;
  kind_t       m_kind = K_NONE;
  int          m_left;
  logic        m_sgn, m_issue, m_drain;
  logic [31:0] m_a, m_b;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic model_update();
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_kind = K_NONE;
      return;
    end
    case (m_kind)
      K_NONE: if (req_valid && !flush && $countones(req_op) == 1) begin
        if (req_op == OP_MTHI) m_hi = req_src1;
        else if (req_op == OP_MTLO) m_lo = req_src1;
        else begin
          m_a = req_src1; m_b = req_src2;
          if (req_op == OP_MULT || req_op == OP_MULTU) begin
            m_kind = K_MUL; m_left = LAT; m_sgn = (req_op == OP_MULT);
          end else begin
            m_kind = K_DIV; m_issue = 1'b1; m_drain = 1'b0; m_sgn = (req_op == OP_DIV);
          end
        end
      end
      K_MUL: if (flush) m_kind = K_NONE;
        else begin
          m_left--;
          if (m_left == 0) begin
            {m_hi, m_lo} = mul_fn(m_sgn, m_a, m_b);
            m_kind = K_NONE;
          end
        end
      K_DIV: if (m_issue) begin
          m_issue = 1'b0;
          if (flush) m_drain = 1'b1;
        end else if (div_out_valid) begin
          if (!m_drain && !flush) {m_hi, m_lo} = div_fn(m_sgn, m_a, m_b);
          m_kind = K_NONE;
        end else if (flush) m_drain = 1'b1;
      default: m_kind = K_NONE;
    endcase
  endtask

  task automatic compare();
    logic [1:0] sop;
    sop = {!m_sgn, m_sgn};
    check("hi", hi_rdata, m_hi);
    check("lo", lo_rdata, m_lo);
    check("busy", hilo_busy, m_kind != K_NONE);
    check("req_ready", req_ready, m_kind == K_NONE && !flush);
    check("mul_op", mul_op, m_kind == K_MUL ? sop : 2'd0);
    check("div_op", div_op, m_kind == K_DIV ? sop : 2'd0);
    check("div_in_valid", div_in_valid, m_kind == K_DIV && m_issue);
    check("div_out_ready", div_out_ready, m_kind == K_DIV && !m_issue);
    if (m_kind == K_MUL) begin
      check("mul_src1", mul_src1, m_a);
      check("mul_src2", mul_src2, m_b);
    end
    if (m_kind == K_DIV) begin
      check("dividend", dividend, m_a);
      check("divisor", divisor, m_b);
    end
  endtask

  // Drive one cycle of inputs (just after a falling edge), then compare after the next rising edge.
  task automatic step(input logic r, input logic f, input logic v, input logic [5:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    rst = r; flush = f; req_valid = v; req_op = op; req_src1 = a; req_src2 = b;
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
  endtask

  task automatic wait_idle(input string name, output int nb, output int np, output int nr);
    nb = 0; np = 0; nr = 0;
    while (hilo_busy && nb < 60) begin
      if (div_in_valid) np++;
      if (req_ready) nr++;
      nb++;
      idle();
    end
    check(name, hilo_busy, 1'b0);
  endtask

  initial begin
    int nb, np, nr;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 6'd0; req_src1 = 32'd0; req_src2 = 32'd0;
    l_req_valid = 1'b0; l_req_op = 6'd0; l_src1 = 32'd0; l_src2 = 32'd0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    check("rst_hi", hi_rdata, 32'd0);
    check("rst_lo", lo_rdata, 32'd0);
    check("rst_busy", hilo_busy, 1'b0);
    check("rst_dividend", dividend, 32'd0);
    check("rst_mul_src1", mul_src1, 32'd0);
    check("rst_l_busy", l_busy, 1'b0);

    // MTHI then MTLO back to back
    step(1'b0, 1'b0, 1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
    step(1'b0, 1'b0, 1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    check("mt_hi", hi_rdata, 32'h1234_5678);
    check("mt_lo", lo_rdata, 32'h9ABC_DEF0);

    // MUL_LAT=1 instance: -2 * 3
    l_req_valid = 1'b1; l_req_op = OP_MULT; l_src1 = 32'hFFFF_FFFE; l_src2 = 32'd3;
    idle();
    l_req_valid = 1'b0;
    check("lat1_busy", l_busy, 1'b1);
    check("lat1_mul_op", l_mul_op, 2'b01);
    idle();
    check("lat1_done", l_busy, 1'b0);
    check("lat1_hi", l_hi, 32'hFFFF_FFFF);
    check("lat1_lo", l_lo, 32'hFFFF_FFFA);

    // MUL_LAT=4 instance: -2 * 3, busy exactly 4 cycles
    step(1'b0, 1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mul_timeout", nb, np, nr);
    check("mul4_busy_cycles", nb, 4);
    check("mul4_hi", hi_rdata, 32'hFFFF_FFFF);
    check("mul4_lo", lo_rdata, 32'hFFFF_FFFA);

    // DIVU 100/7, divider answers after 10 cycles
    div_lat = 10;
    step(1'b0, 1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    wait_idle("divu_timeout", nb, np, nr);
    check("divu_pulses", np, 1);
    check("divu_ready_while_busy", nr, 0);
    check("divu_hi", hi_rdata, 32'd2);
    check("divu_lo", lo_rdata, 32'd14);
    step(1'b0, 1'b0, 1'b1, OP_MULTU, 32'd7, 32'd9);
    check("b2b_accepted", hilo_busy, 1'b1);
    wait_idle("multu_timeout", nb, np, nr);
    check("multu_lo", lo_rdata, 32'd63);

    // DIV -7/2 flushed 3 cycles after issue: drained, nothing written
    step(1'b0, 1'b0, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    idle();
    idle();
    step(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
    check("drain_busy", hilo_busy, 1'b1);
    wait_idle("drain_timeout", nb, np, nr);
    check("drain_ready_while_busy", nr, 0);
    check("drain_hi", hi_rdata, 32'd0);
    check("drain_lo", lo_rdata, 32'd63);

    // Flush coincident with div_out_valid
    div_lat = 3;
    step(1'b0, 1'b0, 1'b1, OP_DIVU, 32'd1000, 32'd10);
    nb = 0;
    while (!div_out_valid && nb < 30) begin nb++; idle(); end
    check("coinc_valid_seen", div_out_valid, 1'b1);
    check("coinc_out_ready", div_out_ready, 1'b1);
    step(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
    check("coinc_idle", hilo_busy, 1'b0);
    check("coinc_lo", lo_rdata, 32'd63);
    // Flush with a request in IDLE: not accepted
    step(1'b0, 1'b1, 1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("flush_idle_hi", hi_rdata, 32'd0);

    // Reset mid-divide, then 5*6
    div_lat = 10;
    step(1'b0, 1'b0, 1'b1, OP_DIV, 32'd50, 32'd5);
    idle();
    idle();
    step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    check("mrst_busy", hilo_busy, 1'b0);
    check("mrst_lo", lo_rdata, 32'd0);
    check("mrst_div_op", div_op, 2'd0);
    check("mrst_dividend", dividend, 32'd0);
    check("mrst_divisor", divisor, 32'd0);
    check("mrst_out_ready", div_out_ready, 1'b0);
    step(1'b0, 1'b0, 1'b1, OP_MULT, 32'd5, 32'd6);
    wait_idle("mult56_timeout", nb, np, nr);
    check("mult56_hi", hi_rdata, 32'd0);
    check("mult56_lo", lo_rdata, 32'd30);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      logic [5:0]  op;
      logic [31:0] b;
      sel = $urandom_range(0, 7);
      if (sel < 6) op = 6'(1 << sel);
      else if (sel == 6) op = 6'd0;
      else op = 6'($urandom);
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      div_lat = $urandom_range(1, 8);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
           op, $urandom, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
